t_flipflop_asy: RTL and testbench



---
 rtl/t_flipflop_asy_pkg.sv | 15 +
 rtl/t_flipflop_asy_tff_cell.sv | 22 ++
 rtl/t_flipflop_asy.sv | 32 +++
 tb/tb_t_flipflop_asy.sv | 135 +++++++++++++
 4 files changed

// File: rtl/t_flipflop_asy_pkg.sv
// Shared constants and the next-state rule for the toggle flip-flop bank.
// A single helper keeps the reset-over-toggle priority defined in one place.
package t_flipflop_asy_pkg;

  localparam int unsigned TFF_MAX_WIDTH = 64;

  // Active-low reset dominates; otherwise the bit flips when t is high.
  function automatic logic tff_next(input logic reset_n,
                                    input logic reset_bit,
                                    input logic q_cur,
                                    input logic t_in);
    return reset_n ? (q_cur ^ t_in) : reset_bit;
  endfunction

endpackage

// File: rtl/t_flipflop_asy_tff_cell.sv
// Single-bit T flip-flop with synchronous active-low reset.
// RESET_BIT is the value loaded while reset is low.
module tff_cell
  import t_flipflop_asy_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    r_q <= tff_next(reset, RESET_BIT, r_q, t);
  end

  assign q = r_q;

endmodule

// File: rtl/t_flipflop_asy.sv
// Bank of WIDTH independent toggle flip-flops sharing clk and a synchronous
// active-low reset; qn is the combinational complement of q.
module t_flipflop_asy
  import t_flipflop_asy_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] w_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell #(
      .RESET_BIT (RESET_VAL[gi])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t[gi]),
      .q     (w_q[gi])
    );
  end

  assign q  = w_q;
  assign qn = ~w_q;

endmodule

// File: tb/tb_t_flipflop_asy.sv
// Scoreboard bench driving a 1-bit and a 4-bit (RESET_VAL=4'b1010) instance
// side by side; expected values are queued per edge and checked after it.
module tb_t_flipflop_asy;

  typedef struct {
    string      tag;
    logic       e1;
    logic [3:0] e4;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       t1;
  logic       q1;
  logic       qn1;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qn4;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  t_flipflop_asy #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .t     (t1),
    .q     (q1),
    .qn    (qn1)
  );

  t_flipflop_asy #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .t     (t4),
    .q     (q4),
    .qn    (qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one edge worth of stimulus, queue its expected result, then check.
  task automatic step(input string tag, input logic rst, input logic t1v,
                      input logic [3:0] t4v, input logic e1, input logic [3:0] e4,
                      input bit glitch);
    exp_t e;
    @(negedge clk);
    reset = rst;
    t1    = t1v;
    t4    = t4v;
    e.tag = tag;
    e.e1  = e1;
    e.e4  = e4;
    sb_q.push_back(e);
    if (glitch) begin
      #2;
      t1 = ~t1v;
      t4 = ~t4v;
      #1;
      t1 = t1v;
      t4 = t4v;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_q1"},  {63'd0, q1},  {63'd0, e.e1});
      chk({e.tag, "_qn1"}, {63'd0, qn1}, {63'd0, ~e.e1});
      chk({e.tag, "_q4"},  {60'd0, q4},  {60'd0, e.e4});
      chk({e.tag, "_qn4"}, {60'd0, qn4}, {60'd0, ~e.e4});
    end
  endtask

  initial begin
    reset = 1'b1;
    t1    = 1'b0;
    t4    = 4'b0000;

    // reset overrides t=all-ones
    step("rst0", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 1'b0);
    step("rst1", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 1'b0);

    // toggle sequence t=1,1,0,1,0 -> 1,0,0,1,1 ; multi-bit independence
    step("seq0", 1'b1, 1'b1, 4'b0110, 1'b1, 4'b1100, 1'b0);
    step("seq1", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0011, 1'b0);
    step("seq2", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0);
    step("seq3", 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0010, 1'b0);
    step("seq4", 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1010, 1'b0);

    // hold with glitches between edges
    for (int k = 0; k < 5; k++)
      step($sformatf("hold%0d", k), 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010, 1'b1);

    // back to q=0 then divide-by-2
    step("rst2", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1010, 1'b0);
    for (int k = 0; k < 8; k++)
      step($sformatf("div%0d", k), 1'b1, 1'b1, 4'b0101,
           (k % 2 == 0) ? 1'b1 : 1'b0,
           (k % 2 == 0) ? 4'b1111 : 4'b1010, 1'b0);

    // reset mid-run discards pending toggles, release applies t against RESET_VAL
    step("mid0", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1010, 1'b0);
    step("mid1", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 1'b0);
    step("mid2", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0101, 1'b0);

    chk("sb_drained", sb_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
